// File: rtl/tile_wr_addr_gen_pkg.sv
// Shared accelerator definitions: tile FSM state encoding and default tile geometry.
package tile_wr_addr_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tile_state_e;

  localparam int unsigned DEF_N0 = 32'd4;
  localparam int unsigned DEF_N1 = 32'd2;
  localparam int unsigned DEF_N2 = 32'd2;
  localparam int unsigned DEF_S1 = 32'd8;
  localparam int unsigned DEF_S2 = 32'd32;

  // Number of beats that make up one complete tile.
  function automatic int unsigned tile_beats(input int unsigned n0, input int unsigned n1,
                                             input int unsigned n2);
    return n0 * n1 * n2;
  endfunction

endpackage

// File: rtl/tile_wr_addr_gen_idx_cnt.sv
// Three-level nested tile index counter (columns, rows, planes) advanced one beat per step.
module tile_idx_cnt
  import tile_wr_addr_gen_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned N0 = DEF_N0,
  parameter int unsigned N1 = DEF_N1,
  parameter int unsigned N2 = DEF_N2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic          wrap0,
  output logic          wrap1,
  output logic          wrap2,
  output logic          last
);

  localparam logic [CW-1:0] MAX0 = CW'(N0 - 32'd1);
  localparam logic [CW-1:0] MAX1 = CW'(N1 - 32'd1);
  localparam logic [CW-1:0] MAX2 = CW'(N2 - 32'd1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] cnt0_q, cnt1_q, cnt2_q;
  logic [CW-1:0] cnt0_d, cnt1_d, cnt2_d;

  // Each wrap flag says that level sits at its terminal index.
  assign wrap0 = (cnt0_q == MAX0);
  assign wrap1 = (cnt1_q == MAX1);
  assign wrap2 = (cnt2_q == MAX2);
  assign last  = wrap0 && wrap1 && wrap2;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;
  assign cnt2  = cnt2_q;

  // Next-index computation with carry from inner to outer level.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
      cnt2_d = '0;
    end else if (step) begin
      if (wrap0) begin
        cnt0_d = '0;
        if (wrap1) begin
          cnt1_d = '0;
          if (wrap2) begin
            cnt2_d = '0;
          end else begin
            cnt2_d = cnt2_q + ONE;
          end
        end else begin
          cnt1_d = cnt1_q + ONE;
        end
      end else begin
        cnt0_d = cnt0_q + ONE;
      end
    end else begin
      cnt0_d = cnt0_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

endmodule

// File: rtl/tile_wr_addr_gen.sv
// Tile write address generator: turns a stream of data beats into memory writes laid
// out as N2 planes of N1 rows of N0 columns starting at a latched base address.
module tile_wr_addr_gen
  import tile_wr_addr_gen_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned N0 = DEF_N0,
  parameter int unsigned N1 = DEF_N1,
  parameter int unsigned N2 = DEF_N2,
  parameter int unsigned S1 = DEF_S1,
  parameter int unsigned S2 = DEF_S2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_ena,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] S1_A = AW'(S1);
  localparam logic [AW-1:0] S2_A = AW'(S2);

  tile_state_e   state_q;
  logic [AW-1:0] plane_base_q, plane_base_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_ena_q, done_q, busy_q;

  logic          start_acc_s, accept_s;
  logic [CW-1:0] cnt0_s, cnt1_s, cnt2_s;
  logic          wrap0_s, wrap1_s, wrap2_s, last_s;
  logic          cnt_hi_unused;

  assign start_acc_s   = (state_q == ST_IDLE) && start;
  assign accept_s      = (state_q == ST_RUN) && in_valid;
  assign cnt_hi_unused = ^{cnt1_s, cnt2_s, wrap2_s};

  tile_idx_cnt #(
    .CW(CW),
    .N0(N0),
    .N1(N1),
    .N2(N2)
  ) u_idx_cnt (
    .clk  (clk),
    .rst  (rst),
    .step (accept_s),
    .clear(start_acc_s),
    .cnt0 (cnt0_s),
    .cnt1 (cnt1_s),
    .cnt2 (cnt2_s),
    .wrap0(wrap0_s),
    .wrap1(wrap1_s),
    .wrap2(wrap2_s),
    .last (last_s)
  );

  // Row/plane base bookkeeping: strides are added when a row or plane completes.
  always_comb begin
    plane_base_d = plane_base_q;
    row_base_d   = row_base_q;
    if (start_acc_s) begin
      plane_base_d = base_addr;
      row_base_d   = base_addr;
    end else if (accept_s && wrap0_s) begin
      if (wrap1_s) begin
        plane_base_d = plane_base_q + S2_A;
        row_base_d   = plane_base_q + S2_A;
      end else begin
        row_base_d   = row_base_q + S1_A;
      end
    end else begin
      row_base_d = row_base_q;
    end
  end

  // Tile FSM together with the registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      plane_base_q <= '0;
      row_base_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_ena_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      plane_base_q <= plane_base_d;
      row_base_q   <= row_base_d;
      wr_ena_q     <= accept_s;
      done_q       <= accept_s && last_s;
      // Busy stays up through the cycle that carries done.
      busy_q       <= start_acc_s || (state_q == ST_RUN);
      if (accept_s) begin
        wr_addr_q <= row_base_q + AW'(cnt0_s);
        wr_data_q <= in_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s && last_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_q == ST_RUN);
  assign wr_ena   = wr_ena_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tile_wr_addr_gen.sv
// Directed bench for tile_wr_addr_gen at default geometry (4 x 2 x 2, strides 8 / 32).
module tb_tile_wr_addr_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_ena;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int total;
  int bad;

  typedef struct {
    logic        start;
    logic [15:0] base;
    logic        valid;
    logic        e_ena;
    logic [15:0] e_addr;
    logic        e_done;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  vec_t        tbl[19];
  logic [15:0] addrs[16];

  tile_wr_addr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_addr(input logic [15:0] b, input int k);
    int off;
    off = (k / 8) * 32 + ((k / 4) % 2) * 8 + (k % 4);
    return b + off[15:0];
  endfunction

  task automatic idle_check(input string nm);
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ena"}, 32'(wr_ena), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  // Starts a tile and feeds 16 beats; gap!=0 toggles in_valid 1,0; a second start
  // pulse with another base is issued when restart_beat beats have been written.
  task automatic run_tile(input string nm, input logic [15:0] base, input int gap,
                          input int restart_beat, input logic [15:0] restart_base);
    int writes;
    int cyc;
    logic acc;
    start     = 1'b1;
    base_addr = base;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_0000;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_start_busy"}, 32'(busy), 32'd1);
    chk({nm, "_start_rdy"}, 32'(in_ready), 32'd1);
    chk({nm, "_start_ena"}, 32'(wr_ena), 32'd0);
    writes = 0;
    cyc    = 0;
    while (writes < 16 && cyc < 100) begin
      in_valid = (gap != 0) ? ((cyc % 2) == 0) : 1'b1;
      in_data  = 32'hC0DE_0000 | 32'(cyc);
      if (writes == restart_beat) begin
        start     = 1'b1;
        base_addr = restart_base;
      end
      acc = in_valid;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        chk({nm, "_ena"}, 32'(wr_ena), 32'd1);
        chk({nm, "_addr"}, 32'(wr_addr), 32'(model_addr(base, writes)));
        chk({nm, "_data"}, wr_data, 32'hC0DE_0000 | 32'(cyc));
        chk({nm, "_done"}, 32'(done), 32'(writes == 15));
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        writes++;
      end else begin
        chk({nm, "_gap_ena"}, 32'(wr_ena), 32'd0);
        chk({nm, "_gap_done"}, 32'(done), 32'd0);
      end
      cyc++;
    end
    chk({nm, "_write_count"}, 32'(writes), 32'd16);
    in_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 32'h0000_0000;

    addrs = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0108, 16'h0109, 16'h010A, 16'h010B,
              16'h0120, 16'h0121, 16'h0122, 16'h0123, 16'h0128, 16'h0129, 16'h012A, 16'h012B};
    tbl[0] = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    for (int i = 1; i <= 16; i++) begin
      tbl[i] = '{1'b0, 16'h0000, 1'b1, 1'b1, addrs[i-1], (i == 16), 1'b1, (i != 16)};
    end
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ena", 32'(wr_ena), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      start     = tbl[i].start;
      base_addr = tbl[i].base;
      in_valid  = tbl[i].valid;
      in_data   = 32'hA500_0000 | 32'(i);
      @(posedge clk); #1;
      chk("tbl_ena", 32'(wr_ena), 32'(tbl[i].e_ena));
      chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_rdy", 32'(in_ready), 32'(tbl[i].e_rdy));
      if (tbl[i].e_ena) begin
        chk("tbl_addr", 32'(wr_addr), 32'(tbl[i].e_addr));
        chk("tbl_data", wr_data, 32'hA500_0000 | 32'(i));
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;

    run_tile("toggle", 16'h0100, 1, -1, 16'h0000);
    idle_check("toggle_after");

    run_tile("restart", 16'h0100, 0, 5, 16'h0300);
    idle_check("restart_after");

    run_tile("wrap", 16'hFFFE, 0, -1, 16'h0000);
    idle_check("wrap_after");

    run_tile("b2b_a", 16'h0040, 0, -1, 16'h0000);
    run_tile("b2b_b", 16'h0400, 0, -1, 16'h0000);
    idle_check("b2b_after");

    // Abandon a tile with reset while beat 9 is being offered.
    start     = 1'b1;
    base_addr = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h5500_0000 | 32'(k);
      @(posedge clk); #1;
      chk("abort_pre_addr", 32'(wr_addr), 32'(addrs[k]));
      chk("abort_pre_ena", 32'(wr_ena), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ena", 32'(wr_ena), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    chk("abort_addr", 32'(wr_addr), 32'd0);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("abort_quiet_ena", 32'(wr_ena), 32'd0);
      chk("abort_quiet_done", 32'(done), 32'd0);
    end
    run_tile("fresh", 16'h0200, 0, -1, 16'h0000);
    idle_check("fresh_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
